// File: rtl/as_pack.sv
// as_pack: shared JTAG TAP state encoding and I-Mem loader sizing.
package as_pack;
    localparam int imem_addr_width = 10;
    localparam int instr_width = 32;
    localparam int im_scan_length = imem_addr_width + instr_width + 1;
    localparam logic [7:0] IMDR_IR = 8'h80;
    typedef enum logic [3:0] {
        TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PAU_DR, TAP_EX2_DR,
        TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PAU_IR, TAP_EX2_IR, TAP_UPD_IR
    } tap_state_t;
    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        case (s)
            TAP_TLR:    return tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    return tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: return tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: return tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  return tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: return tms ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: return tms ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: return tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: return tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: return tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: return tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  return tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: return tms ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: return tms ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: return tms ? TAP_UPD_IR : TAP_SH_IR;
            default:    return tms ? TAP_SEL_DR : TAP_RTI;
        endcase
    endfunction
endpackage

// File: rtl/as_jtag_sync.sv
// as_jtag_sync: 2-flop synchronisers for the JTAG pins plus tck edge strobes.
module as_jtag_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tck_i,
    input  logic tms_i,
    input  logic tdi_i,
    input  logic trst_i,
    output logic tck_rise_o,
    output logic tck_fall_o,
    output logic tms_o,
    output logic tdi_o,
    output logic trst_o
);
    logic [2:0] tck_q;
    logic [1:0] tms_q, tdi_q, trst_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tck_q  <= '0;
            tms_q  <= '0;
            tdi_q  <= '0;
            trst_q <= '0;
        end else begin
            tck_q  <= {tck_q[1:0], tck_i};
            tms_q  <= {tms_q[0], tms_i};
            tdi_q  <= {tdi_q[0], tdi_i};
            trst_q <= {trst_q[0], trst_i};
        end
    end
    assign tck_rise_o = tck_q[1] & ~tck_q[2];
    assign tck_fall_o = ~tck_q[1] & tck_q[2];
    assign tms_o      = tms_q[1];
    assign tdi_o      = tdi_q[1];
    assign trst_o     = trst_q[1];
endmodule

// File: rtl/as_imem_jtag_loader.sv
// as_imem_jtag_loader: oversampled JTAG TAP whose IMDR scans become I-Mem write requests.
module as_imem_jtag_loader #(
    parameter int              IR_W    = 8,
    parameter logic [IR_W-1:0] IMDR_IR = as_pack::IMDR_IR,
    parameter int              ADDR_W  = as_pack::imem_addr_width,
    parameter int              DATA_W  = as_pack::instr_width,
    parameter int              SCAN_W  = ADDR_W + DATA_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tck_i,
    input  logic              trst_i,
    input  logic              tms_i,
    input  logic              tdi_i,
    output logic              tdo_o,
    output logic              imWe_o,
    output logic [ADDR_W-1:0] imAddr_o,
    output logic [DATA_W-1:0] imData_o,
    input  logic              imReady_i,
    output logic              imErr_o
);
    import as_pack::*;
    tap_state_t state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_sr_q;
    logic [SCAN_W-1:0] imdr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic bypass_q, upd_q, tdo_q, we_q, err_q;
    logic tck_rise, tck_fall, tms, tdi, trst, imdr_sel;

    as_jtag_sync u_sync (
        .clk_i(clk_i), .rst_i(rst_i), .tck_i(tck_i), .tms_i(tms_i), .tdi_i(tdi_i), .trst_i(trst_i),
        .tck_rise_o(tck_rise), .tck_fall_o(tck_fall), .tms_o(tms), .tdi_o(tdi), .trst_o(trst)
    );

    assign state_d  = tap_next(state_q, tms);
    assign imdr_sel = ir_q == IMDR_IR;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= TAP_TLR;
            ir_q     <= IR_W'(1);
            ir_sr_q  <= '0;
            imdr_q   <= '0;
            bypass_q <= 1'b0;
            upd_q    <= 1'b0;
            tdo_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            upd_q <= 1'b0;
            if (trst) begin
                state_q <= TAP_TLR;
            end else if (tck_rise) begin
                state_q <= state_d;
                // Actions key off the state being left, so the Capture->Shift rise never shifts
                case (state_q)
                    TAP_CAP_IR: ir_sr_q <= IR_W'(1);
                    TAP_SH_IR:  ir_sr_q <= {ir_sr_q[IR_W-2:0], tdi};
                    TAP_CAP_DR: bypass_q <= 1'b0;
                    TAP_SH_DR:  if (imdr_sel) imdr_q <= {imdr_q[SCAN_W-2:0], tdi}; else bypass_q <= tdi;
                    default: ;
                endcase
                if (state_d == TAP_UPD_IR) ir_q <= ir_sr_q;
                upd_q <= state_d == TAP_UPD_DR;
            end
            if (state_q == TAP_TLR) ir_q <= IR_W'(1);
            if (tck_fall)
                tdo_q <= state_q == TAP_SH_IR ? ir_sr_q[IR_W-1] :
                         state_q == TAP_SH_DR ? (imdr_sel ? imdr_q[SCAN_W-1] : bypass_q) : 1'b0;
            if (we_q && imReady_i) we_q <= 1'b0;
            // A new word arriving while a request is still outstanding is dropped, not queued
            if (upd_q && imdr_sel && imdr_q[0]) begin
                if (we_q) begin
                    err_q <= 1'b1;
                end else begin
                    we_q   <= 1'b1;
                    addr_q <= imdr_q[SCAN_W-1 -: ADDR_W];
                    data_q <= imdr_q[DATA_W:1];
                end
            end
        end
    end

    assign tdo_o    = tdo_q;
    assign imWe_o   = we_q;
    assign imAddr_o = addr_q;
    assign imData_o = data_q;
    assign imErr_o  = err_q;
endmodule
